// File: rtl/muladd_seq_ctrl.sv
// rtl/muladd_seq_ctrl.sv - job sequencer for the 4-lane Q8.8 multiply-add datapath
module muladd_seq_ctrl #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 8,
    parameter int ACC_W  = 24
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [63:0]       mem_a,
    input  logic [63:0]       mem_b,
    output logic [63:0]       dp_a,
    output logic [63:0]       dp_b,
    input  logic [15:0]       dp_sum,
    output logic [15:0]       result,
    output logic              sat,
    output logic              result_valid,
    input  logic              result_ready
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, OUT} state_t;

    localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'(32'sd32767);
    localparam logic signed [ACC_W-1:0] Q_MIN = ACC_W'(-32'sd32768);

    state_t                   state;
    state_t                   next_state;
    logic                     accept;
    logic                     enter_out;
    logic [LEN_W-1:0]         beats_left;
    logic [1:0]               vpipe;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_next;

    // Operands go straight from the RAM read port into the datapath.
    assign dp_a = mem_a;
    assign dp_b = mem_b;

    // The beat whose dp_sum is visible now (stage 2) is folded in on this edge.
    assign acc_next = vpipe[1] ? acc + {{(ACC_W-16){dp_sum[15]}}, dp_sum} : acc;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and strobes; DRAIN leaves as the final beat is being accumulated so the
    // result is registered on that same edge.
    always_comb begin
        next_state   = state;
        accept       = 1'b0;
        enter_out    = 1'b0;
        mem_rd       = 1'b0;
        result_valid = 1'b0;
        busy         = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = (len == '0) ? OUT : FETCH;
                end
            end
            FETCH: begin
                mem_rd = 1'b1;
                if (beats_left == LEN_W'(1)) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (!vpipe[0]) begin
                    enter_out  = 1'b1;
                    next_state = OUT;
                end
            end
            OUT: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Address generation, beat tracking, accumulation and saturated result capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_addr   <= '0;
            beats_left <= '0;
            vpipe      <= '0;
            acc        <= '0;
            result     <= '0;
            sat        <= 1'b0;
        end else begin
            vpipe <= {vpipe[0], mem_rd};
            if (accept) begin
                mem_addr   <= base_addr;
                beats_left <= len;
                acc        <= '0;
                sat        <= 1'b0;
                if (len == '0) begin
                    result <= '0;
                end
            end else begin
                if (mem_rd) begin
                    mem_addr   <= mem_addr + 1'b1;
                    beats_left <= beats_left - 1'b1;
                end
                acc <= acc_next;
                if (enter_out) begin
                    if (acc_next > Q_MAX) begin
                        result <= 16'h7FFF;
                        sat    <= 1'b1;
                    end else if (acc_next < Q_MIN) begin
                        result <= 16'h8000;
                        sat    <= 1'b1;
                    end else begin
                        result <= acc_next[15:0];
                        sat    <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_muladd_seq_ctrl.sv
// tb/tb_muladd_seq_ctrl.sv - self-checking bench for muladd_seq_ctrl
module tb_muladd_seq_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  base_addr = '0;
    logic [7:0]  len = '0;
    logic        busy;
    logic        mem_rd;
    logic [9:0]  mem_addr;
    logic [63:0] mem_a = '0;
    logic [63:0] mem_b = '0;
    logic [63:0] dp_a;
    logic [63:0] dp_b;
    logic [15:0] dp_sum = '0;
    logic [15:0] result;
    logic        sat;
    logic        result_valid;
    logic        result_ready = 1'b0;

    logic [63:0] ram_a [0:1023];
    logic [63:0] ram_b [0:1023];
    logic [16:0] exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    muladd_seq_ctrl #(.ADDR_W(10), .LEN_W(8), .ACC_W(24)) dut (
        .clock(clock), .reset(reset), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_a(mem_a), .mem_b(mem_b),
        .dp_a(dp_a), .dp_b(dp_b), .dp_sum(dp_sum), .result(result), .sat(sat),
        .result_valid(result_valid), .result_ready(result_ready)
    );

    always #5 clock = ~clock;

    // 4 signed Q8.8 products, each trimmed to [23:8], summed with 16-bit wrap.
    function automatic logic [15:0] dp_model(input logic [63:0] a, input logic [63:0] b);
        logic [15:0] s;
        logic signed [31:0] p;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            p = $signed(a[16*i +: 16]) * $signed(b[16*i +: 16]);
            s = s + p[23:8];
        end
        return s;
    endfunction

    // Operand RAM (1-cycle read) and registered datapath.
    always @(posedge clock) begin
        if (mem_rd) begin
            mem_a <= ram_a[mem_addr];
            mem_b <= ram_b[mem_addr];
        end
        dp_sum <= dp_model(dp_a, dp_b);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [9:0] b, input int n, input logic [15:0] a_lane, input logic [15:0] b_lane);
        logic [9:0] w;
        for (int k = 0; k < n; k++) begin
            w = b + 10'(k);
            ram_a[w] = {4{a_lane}};
            ram_b[w] = {4{b_lane}};
        end
    endtask

    task automatic fill_rand(input logic [9:0] b, input int n);
        logic [9:0] w;
        for (int k = 0; k < n; k++) begin
            w = b + 10'(k);
            ram_a[w] = {$urandom, $urandom};
            ram_b[w] = {$urandom, $urandom};
        end
    endtask

    // Reference: sum of per-beat datapath outputs, then clamp to Q8.8.
    function automatic logic [16:0] ref_job(input logic [9:0] b, input int n);
        longint acc;
        logic [9:0] w;
        logic [15:0] beat;
        acc = 0;
        for (int k = 0; k < n; k++) begin
            w = b + 10'(k);
            beat = dp_model(ram_a[w], ram_b[w]);
            acc += longint'($signed(beat));
        end
        if (acc > 32767) return {1'b1, 16'h7FFF};
        if (acc < -32768) return {1'b1, 16'h8000};
        return {1'b0, acc[15:0]};
    endfunction

    task automatic run_job(input string tag, input logic [9:0] b, input int n, input int hold, input bit poke);
        int edges;
        int reads;
        logic [9:0] ea;
        logic [16:0] e;
        logic [15:0] held;
        exp_q.push_back(ref_job(b, n));
        @(negedge clock);
        start = 1'b1; base_addr = b; len = 8'(n);
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        edges = 0; reads = 0;
        while (!result_valid && edges < 400) begin
            if (mem_rd) begin
                ea = b + 10'(reads);
                check_eq({tag, "_addr"}, 32'(mem_addr), 32'(ea));
                reads++;
            end
            start = poke && (edges == 2);
            base_addr = 10'h155; len = 8'd7;
            @(posedge clock);
            edges++;
            @(negedge clock);
        end
        start = 1'b0;
        if (!result_valid) begin
            check_eq({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        check_eq({tag, "_reads"}, 32'(reads), 32'(n));
        check_eq({tag, "_latency"}, 32'(edges), (n == 0) ? 32'd0 : 32'(n + 2));
        if (exp_q.size() == 0) begin
            check_eq({tag, "_queue"}, 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check_eq({tag, "_result"}, 32'(result), 32'(e[15:0]));
        check_eq({tag, "_sat"}, 32'(sat), 32'(e[16]));
        held = result;
        for (int i = 0; i < hold; i++) begin
            start = poke;
            @(posedge clock);
            @(negedge clock);
            check_eq({tag, "_hold_valid"}, 32'(result_valid), 32'd1);
            check_eq({tag, "_hold_result"}, 32'(result), 32'(held));
        end
        start = 1'b0;
        result_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        result_ready = 1'b0;
        check_eq({tag, "_valid_drop"}, 32'(result_valid), 32'd0);
        check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram_a[i] = '0;
            ram_b[i] = '0;
        end
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_mem_rd", 32'(mem_rd), 32'd0);
        check_eq("rst_valid", 32'(result_valid), 32'd0);
        check_eq("rst_sat", 32'(sat), 32'd0);
        check_eq("rst_result", 32'(result), 32'd0);
        check_eq("rst_addr", 32'(mem_addr), 32'd0);
        reset = 1'b0;

        fill(10'h000, 1, 16'h0100, 16'h0100);
        run_job("t1", 10'h000, 1, 0, 1'b0);
        fill(10'h3FE, 4, 16'h0200, 16'h0080);
        run_job("t2", 10'h3FE, 4, 0, 1'b1);
        fill(10'h010, 3, 16'h7F00, 16'h0100);
        run_job("t3", 10'h010, 3, 0, 1'b0);
        fill(10'h100, 200, 16'h0100, 16'h0100);
        run_job("t4_pos", 10'h100, 200, 0, 1'b0);
        fill(10'h100, 200, 16'h7F00, 16'h0100);
        run_job("t4_neg", 10'h100, 200, 0, 1'b0);
        run_job("t5_len0", 10'h055, 0, 3, 1'b1);
        run_job("t6_hold", 10'h000, 1, 10, 1'b1);

        // Abort a long job mid-FETCH.
        fill(10'h200, 50, 16'h7F00, 16'h7F00);
        @(negedge clock);
        start = 1'b1; base_addr = 10'h200; len = 8'd50;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        check_eq("abort_fetching", 32'(mem_rd), 32'd1);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_mem_rd", 32'(mem_rd), 32'd0);
        check_eq("abort_valid", 32'(result_valid), 32'd0);
        fill(10'h020, 2, 16'h0100, 16'h0300);
        run_job("t6_after", 10'h020, 2, 0, 1'b0);

        fill_rand(10'h3F0, 20);
        run_job("rand", 10'h3F0, 20, 2, 1'b0);

        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
